// File: rtl/add_serial.sv
// add_serial: chunk-serial adder, CHUNK bits per clock, WIDTH/CHUNK cycles per operation.
// Optional subtraction (a + ~b + 1) is enabled by defining ADD_SERIAL_SUB_EN.
module add_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CW1    = CHUNK + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d;

    logic             sub_eff;
    logic [SW-1:0]    off;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   ch_sum;
    logic             msb_cin;

`ifdef ADD_SERIAL_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Chunk adder on the slice selected by k; also derives carry into the slice MSB.
    always_comb begin
        off     = SW'(32'(k_q) * CHUNK);
        a_ch    = a_q[off +: CHUNK];
        b_ch    = b_q[off +: CHUNK];
        ch_sum  = CW1'(a_ch) + CW1'(b_ch) + CW1'(carry_q);
        msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1];
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum;
        cout_d  = cout;
        ovf_d   = overflow;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub_eff ? ~b : b;
                    carry_d = sub_eff ? 1'b1 : cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[off +: CHUNK] = ch_sum[CHUNK-1:0];
                carry_d             = ch_sum[CHUNK];
                k_d                 = k_q + KW'(1);
                if (k_q == KW'(NCHUNK - 1)) begin
                    k_d     = '0;
                    cout_d  = ch_sum[CHUNK];
                    ovf_d   = msb_cin ^ ch_sum[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            k_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            k_q       <= k_d;
            sum       <= sum_d;
            cout      <= cout_d;
            overflow  <= ovf_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

endmodule

// File: doc/add_serial.md
ADD_SERIAL -- requirements
Module: add_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands present.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have ports a and b, input, WIDTH: operands.
REQ-008 SHALL have port cin, input, 1: carry-in.
REQ-009 SHALL have port sub, input, 1, present only under ADD_SERIAL_SUB_EN: selects subtraction.
REQ-010 SHALL have port out_valid, output, 1: result present.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port sum, output, WIDTH: result.
REQ-013 SHALL have port cout, output, 1: carry out of bit WIDTH-1.
REQ-014 SHALL have port overflow, output, 1: two's-complement signed overflow.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept occurs on an edge where in_valid and in_ready are both 1: a, b, cin (and sub) are registered, the chunk index is set to 0, and the state moves IDLE to RUN.
REQ-018 Operands SHALL NOT be sampled outside the accept edge; input changes during RUN or DONE SHALL have no effect.
REQ-019 Each RUN edge adds chunk k, bits [k*CHUNK +: CHUNK], of A and B plus the carry register, writes that chunk of sum, updates the carry register and increments k.
REQ-020 The carry register SHALL be initialised to cin at accept.
REQ-021 After the edge that processes chunk NCHUNK-1, the state SHALL move RUN to DONE.
REQ-022 out_valid SHALL rise exactly NCHUNK edges after the accept edge; with WIDTH=32 and CHUNK=8 that is 4 edges.
REQ-023 In DONE, sum, cout and overflow SHALL be held stable until an edge where out_ready is 1; that edge moves the state to IDLE.
REQ-024 in_ready SHALL NOT be asserted in the same cycle as out_valid; the maximum throughput is one operation per NCHUNK+2 cycles.
REQ-025 cout SHALL equal the final carry register value.
REQ-026 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; all-ones + 1 SHALL give sum 0 and cout 1.
REQ-028 When CHUNK equals WIDTH, the block SHALL still run one RUN cycle, so latency is 1.
REQ-029 sum, cout and overflow SHALL be 0 in IDLE; partial sums SHALL be undefined to the consumer during RUN but SHALL be 0 after reset.

Reset
REQ-030 When reset is 1 on an edge, the state SHALL go to IDLE and sum, cout, overflow, the carry register and k SHALL be cleared to 0.
REQ-031 Reset values SHALL be in_ready=1, out_valid=0, sum=0, cout=0, overflow=0.
REQ-032 Reset in RUN or DONE SHALL abort the operation, discard the result and produce no out_valid pulse.
REQ-033 Reset SHALL take priority over an accept or an out_ready handshake on the same edge.

Configuration
REQ-034 Macro ADD_SERIAL_SUB_EN SHALL control subtraction support.
REQ-035 With ADD_SERIAL_SUB_EN defined, the sub port SHALL exist; sub=1 at accept SHALL compute a + ~b + 1 with cin ignored, and cout=1 SHALL mean no borrow.
REQ-036 With ADD_SERIAL_SUB_EN undefined, the sub port SHALL be absent and the block SHALL only add.

Verification (WIDTH=32, CHUNK=8)
REQ-037 Basic add: a=0x0000_0001, b=0x0000_0002, cin=0 -> out_valid 4 edges after accept; sum=0x0000_0003, cout=0, overflow=0.
REQ-038 Full carry ripple across all chunks: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x0000_0000, cout=1, overflow=0.
REQ-039 Signed overflow: a=0x7FFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x8000_0000, cout=0, overflow=1.
REQ-040 Backpressure: hold out_ready=0 for 10 cycles while changing a, b and in_valid -> sum stays stable, in_ready=0, and exactly one result is delivered when out_ready=1.
REQ-041 Reset mid-operation: assert reset 2 edges after accept -> next cycle in_ready=1, out_valid=0, sum=0, and no stale out_valid follows.
REQ-042 With ADD_SERIAL_SUB_EN defined, sub=1, a=0x0000_0005, b=0x0000_0007 -> sum=0xFFFF_FFFE, cout=0, overflow=0.
